bster_cmd_ingress: RTL and testbench
====================================

// Module: bster_cmd_ingress
//
// PURPOSE
// - Command front-end of the bster core. Sits between the cmd_tvalid/cmd_tready/cmd_tdata AXI4-Stream slave and the tree engine.
// - Buffers raw commands in a small FIFO and decodes opcode, tag, key and data.
// - Issues valid commands to the engine over a valid/ready port.
// - Rejects illegal opcodes itself with an error on the status stream; the engine never sees them.
//
// PARAMETERS
// - CMD_WIDTH   128  raw command width. Fixed layout, see BEHAVIOUR.
// - STS_WIDTH   8    status word width.
// - KEY_WIDTH   32   tree key width.
// - DATA_WIDTH  64   payload width.
// - TAG_WIDTH   8    command tag width.
// - FIFO_DEPTH  4    raw command buffer depth. Power of 2, >= 2.
//
// PORTS
// - aclk          in   1                      core clock.
// - aresetn       in   1                      asynchronous active-low reset.
// - csr_enable    in   1                      1: accept commands. 0: cmd_tready=0; the block still drains buffered commands.
// - csr_flush     in   1                      single-cycle pulse: discard all buffered commands.
// - cmd_tvalid    in   1                      command stream valid.
// - cmd_tready    out  1                      command stream ready.
// - cmd_tdata     in   CMD_WIDTH              raw command.
// - eng_valid     out  1                      decoded command valid, to engine.
// - eng_ready     in   1                      engine accepts the command.
// - eng_op        out  2                      1=INSERT, 2=DELETE, 3=SEARCH.
// - eng_tag       out  TAG_WIDTH              command tag.
// - eng_key       out  KEY_WIDTH              key.
// - eng_data      out  DATA_WIDTH             payload. Meaningful for INSERT only.
// - sts_tvalid    out  1                      reject status valid.
// - sts_tready    in   1                      reject status ready.
// - sts_tdata     out  STS_WIDTH              {4'hE, opcode[3:0]}.
// - cnt_accepted  out  32                     commands issued to the engine. Saturating.
// - cnt_rejected  out  32                     commands rejected. Saturating.
// - fifo_level    out  $clog2(FIFO_DEPTH)+1   current buffer occupancy.
//
// BEHAVIOUR
// - Reset (aresetn=0, asynchronous): all outputs 0, except cmd_tready, which also follows the FIFO empty/disabled state. FIFO empty, FSM in IDLE, counters 0.
// - Command layout: [3:0] opcode, [7:4] reserved, [15:8] tag, [47:16] key, [111:48] data, [127:112] ignored.
// - Accept rule: cmd_tready = csr_enable & !full. Uses the registered full flag; no same-cycle pop bypass.
// - A beat is pushed when cmd_tvalid & cmd_tready.
// - FSM states:
//   - IDLE: FIFO empty, no outputs valid.
//   - ISSUE: eng_valid=1, fields held stable until eng_ready.
//   - REJECT: sts_tvalid=1, status held stable until sts_tready.
// - From IDLE with FIFO non-empty: pop the head, register the decoded fields, then go to ISSUE if opcode is in 1..3, else REJECT.
// - In ISSUE or REJECT when the handshake completes:
//   - if the FIFO is non-empty, pop the next head in the same cycle and enter ISSUE or REJECT for it. Back-to-back rate is 1 command/cycle.
//   - otherwise go to IDLE.
// - Latency: a beat accepted in cycle N drives eng_valid or sts_tvalid in cycle N+2, when the FIFO was empty and the FSM was IDLE.
// - Once asserted, eng_valid and sts_tvalid never drop, and their fields never change, until the handshake completes. This is AXI-Stream compliant.
// - Simultaneous push and pop: occupancy is unchanged; both operations happen.
// - Full: cmd_tready=0 until a pop. A pop in cycle N gives cmd_tready=1 in N+1.
// - Pointers wrap modulo FIFO_DEPTH. Occupancy is tracked with an extra MSB so full and empty are unambiguous.
// - csr_flush:
//   - clears FIFO pointers next cycle; a push in the same cycle is dropped.
//   - does NOT cancel a pending eng_valid or sts_tvalid; the current handshake completes, after which the FSM goes to IDLE.
//   - flushed commands are not counted.
// - csr_enable deassertion mid-stream: a beat presented in that cycle is not accepted; buffered commands drain normally.
// - cnt_accepted increments on eng_valid & eng_ready. cnt_rejected increments on sts_tvalid & sts_tready. Both hold at 32'hFFFF_FFFF.
// - Reset mid-operation: immediately returns everything to the reset state. In-flight commands are lost.
//
// STRUCTURE
// - bster_pkg holds:
//   - opcode enum: OP_INSERT=1, OP_DELETE=2, OP_SEARCH=3;
//   - field offset/width localparams for the command layout;
//   - STS_BAD_OPCODE = 4'hE;
//   - FSM state enum {IDLE, ISSUE, REJECT}.
// - Sub-module bster_sync_fifo (WIDTH, DEPTH; push, pop, flush, full, empty, level). Holds raw command words. Reusable by the completion path.
// - Decode and the FSM live in this module.
//
// TESTING
// 1. Reset, then a single INSERT (op=1, tag=8'h5A, key=32'h0000_1234, data=64'hDEAD_BEEF_0000_0001), eng_ready=1 -> eng_valid in cycle N+2 with those fields; cnt_accepted=1.
// 2. Illegal op=4'h7, tag=8'h03 -> no eng_valid; sts_tdata=8'hE7 held until sts_tready; cnt_rejected=1.
// 3. eng_ready=0, push 5 commands with FIFO_DEPTH=4 -> 4 accepted into the FIFO plus 1 latched at the output; cmd_tready=0. Then eng_ready=1 -> 5 issued back-to-back in push order, one per cycle.
// 4. Interleave SEARCH, bad op 4'h0, DELETE with sts_tready stalled 3 cycles -> DELETE waits behind the reject; order preserved; counters 2/1.
// 5. FIFO holds 3 commands and eng_valid is pending; pulse csr_flush -> pending command still completes; then IDLE; fifo_level=0; cnt_accepted +1 only.
// 6. csr_enable=0 with cmd_tvalid=1 -> cmd_tready=0 for all cycles. Assert aresetn=0 mid-ISSUE -> eng_valid=0 immediately; counters 0.

Source files
------------

// File: rtl/bster_pkg.sv
// Shared types and command-layout constants for the bster core.
package bster_pkg;

    typedef enum logic [3:0] {
        OP_INSERT = 4'd1,
        OP_DELETE = 4'd2,
        OP_SEARCH = 4'd3
    } op_e;

    localparam int OP_LSB   = 0;
    localparam int OP_W     = 4;
    localparam int RSV_LSB  = 4;
    localparam int RSV_W    = 4;
    localparam int TAG_LSB  = 8;
    localparam int KEY_LSB  = 16;
    localparam int DATA_LSB = 48;
    localparam int CMD_USED = 112;

    localparam logic [3:0] STS_BAD_OPCODE = 4'hE;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        REJECT
    } state_e;

    function automatic logic is_legal_op(input logic [3:0] op);
        return (op == OP_INSERT) || (op == OP_DELETE) || (op == OP_SEARCH);
    endfunction

endpackage

// File: rtl/bster_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers so full and empty are unambiguous.
module bster_sync_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    // A flush wins over a same-cycle push so the discarded state is truly empty.
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rptr[AW-1:0]];
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign level = wptr - rptr;

endmodule

// File: rtl/bster_cmd_ingress.sv
// Command front-end: buffers raw commands, decodes them, and issues legal ones
// to the tree engine while answering illegal opcodes on the status stream.
module bster_cmd_ingress
    import bster_pkg::*;
#(
    parameter int CMD_WIDTH  = 128,
    parameter int STS_WIDTH  = 8,
    parameter int KEY_WIDTH  = 32,
    parameter int DATA_WIDTH = 64,
    parameter int TAG_WIDTH  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          csr_enable,
    input  logic                          csr_flush,
    input  logic                          cmd_tvalid,
    output logic                          cmd_tready,
    input  logic [CMD_WIDTH-1:0]          cmd_tdata,
    output logic                          eng_valid,
    input  logic                          eng_ready,
    output logic [1:0]                    eng_op,
    output logic [TAG_WIDTH-1:0]          eng_tag,
    output logic [KEY_WIDTH-1:0]          eng_key,
    output logic [DATA_WIDTH-1:0]         eng_data,
    output logic                          sts_tvalid,
    input  logic                          sts_tready,
    output logic [STS_WIDTH-1:0]          sts_tdata,
    output logic [31:0]                   cnt_accepted,
    output logic [31:0]                   cnt_rejected,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    state_e                state;
    state_e                state_next;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CMD_WIDTH-1:0]  head;
    logic [3:0]            head_op;
    logic                  push;
    logic                  done;
    logic                  load;
    logic [1:0]            op_q;
    logic [TAG_WIDTH-1:0]  tag_q;
    logic [KEY_WIDTH-1:0]  key_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [STS_WIDTH-1:0]  sts_q;
    logic                  unused_bits;

    assign cmd_tready = csr_enable & ~fifo_full;
    assign push       = cmd_tvalid & cmd_tready;
    assign head_op    = head[OP_LSB +: OP_W];
    assign done       = ((state == ISSUE) & eng_ready) | ((state == REJECT) & sts_tready);
    // A flush cycle never pops: the buffered commands are being discarded.
    assign load       = ~csr_flush & ~fifo_empty & ((state == IDLE) | done);
    assign unused_bits = ^{head[RSV_LSB +: RSV_W], head[CMD_WIDTH-1:CMD_USED]};

    bster_sync_fifo #(
        .WIDTH (CMD_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (aclk),
        .rst_n (aresetn),
        .push  (push),
        .pop   (load),
        .flush (csr_flush),
        .wdata (cmd_tdata),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (load)      state_next = is_legal_op(head_op) ? ISSUE : REJECT;
        else if (done) state_next = IDLE;
    end

    always_comb begin
        eng_valid  = 1'b0;
        sts_tvalid = 1'b0;
        case (state)
            ISSUE:   eng_valid  = 1'b1;
            REJECT:  sts_tvalid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            op_q   <= '0;
            tag_q  <= '0;
            key_q  <= '0;
            data_q <= '0;
            sts_q  <= '0;
        end else if (load) begin
            op_q   <= head_op[1:0];
            tag_q  <= head[TAG_LSB +: TAG_WIDTH];
            key_q  <= head[KEY_LSB +: KEY_WIDTH];
            data_q <= head[DATA_LSB +: DATA_WIDTH];
            sts_q  <= STS_WIDTH'({STS_BAD_OPCODE, head_op});
        end
    end

    assign eng_op    = op_q;
    assign eng_tag   = tag_q;
    assign eng_key   = key_q;
    assign eng_data  = data_q;
    assign sts_tdata = sts_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_accepted <= '0;
            cnt_rejected <= '0;
        end else begin
            if (eng_valid && eng_ready && cnt_accepted != CNT_MAX)
                cnt_accepted <= cnt_accepted + 32'd1;
            if (sts_tvalid && sts_tready && cnt_rejected != CNT_MAX)
                cnt_rejected <= cnt_rejected + 32'd1;
        end
    end

endmodule

// File: tb/tb_bster_cmd_ingress.sv
// Directed bench for bster_cmd_ingress: hand-computed expectations checked
// with immediate assertions after each clock edge.
module tb_bster_cmd_ingress;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          csr_enable;
    logic          csr_flush;
    logic          cmd_tvalid;
    logic          cmd_tready;
    logic [127:0]  cmd_tdata;
    logic          eng_valid;
    logic          eng_ready;
    logic [1:0]    eng_op;
    logic [7:0]    eng_tag;
    logic [31:0]   eng_key;
    logic [63:0]   eng_data;
    logic          sts_tvalid;
    logic          sts_tready;
    logic [7:0]    sts_tdata;
    logic [31:0]   cnt_accepted;
    logic [31:0]   cnt_rejected;
    logic [2:0]    fifo_level;

    int pass_count = 0;
    int check_count = 0;

    bster_cmd_ingress dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .csr_enable   (csr_enable),
        .csr_flush    (csr_flush),
        .cmd_tvalid   (cmd_tvalid),
        .cmd_tready   (cmd_tready),
        .cmd_tdata    (cmd_tdata),
        .eng_valid    (eng_valid),
        .eng_ready    (eng_ready),
        .eng_op       (eng_op),
        .eng_tag      (eng_tag),
        .eng_key      (eng_key),
        .eng_data     (eng_data),
        .sts_tvalid   (sts_tvalid),
        .sts_tready   (sts_tready),
        .sts_tdata    (sts_tdata),
        .cnt_accepted (cnt_accepted),
        .cnt_rejected (cnt_rejected),
        .fifo_level   (fifo_level)
    );

    always #5 aclk = ~aclk;

    function automatic logic [127:0] mk_cmd(input logic [3:0] op, input logic [7:0] tag,
                                            input logic [31:0] key, input logic [63:0] data);
        return {16'hA5A5, data, key, tag, 4'hF, op};
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic [127:0] cmd);
        cmd_tvalid = 1'b1;
        cmd_tdata  = cmd;
        tick();
        cmd_tvalid = 1'b0;
    endtask

    initial begin
        aresetn    = 1'b0;
        csr_enable = 1'b1;
        csr_flush  = 1'b0;
        cmd_tvalid = 1'b0;
        cmd_tdata  = '0;
        eng_ready  = 1'b0;
        sts_tready = 1'b0;
        #2;
        checkOutput("rst_eng_valid", eng_valid, 0);
        checkOutput("rst_sts_tvalid", sts_tvalid, 0);
        checkOutput("rst_sts_tdata", sts_tdata, 0);
        checkOutput("rst_eng_tag", eng_tag, 0);
        checkOutput("rst_cnt_acc", cnt_accepted, 0);
        checkOutput("rst_cnt_rej", cnt_rejected, 0);
        checkOutput("rst_level", fifo_level, 0);
        checkOutput("rst_tready", cmd_tready, 1);
        tick();
        aresetn = 1'b1;
        tick();

        $display("[TB] step 1: single INSERT");
        applyStimulus(mk_cmd(4'h1, 8'h5A, 32'h0000_1234, 64'hDEAD_BEEF_0000_0001));
        checkOutput("t1_level_n1", fifo_level, 1);
        checkOutput("t1_valid_n1", eng_valid, 0);
        tick();
        checkOutput("t1_valid_n2", eng_valid, 1);
        checkOutput("t1_op", eng_op, 1);
        checkOutput("t1_tag", eng_tag, 8'h5A);
        checkOutput("t1_key", eng_key, 32'h0000_1234);
        checkOutput("t1_data", eng_data, 64'hDEAD_BEEF_0000_0001);
        checkOutput("t1_level_n2", fifo_level, 0);
        eng_ready = 1'b1;
        tick();
        eng_ready = 1'b0;
        checkOutput("t1_valid_done", eng_valid, 0);
        checkOutput("t1_cnt_acc", cnt_accepted, 1);

        $display("[TB] step 2: illegal opcode 7");
        applyStimulus(mk_cmd(4'h7, 8'h03, 32'h1111_2222, 64'h0));
        tick();
        checkOutput("t2_sts_valid", sts_tvalid, 1);
        checkOutput("t2_sts_data", sts_tdata, 8'hE7);
        checkOutput("t2_no_eng", eng_valid, 0);
        tick();
        tick();
        checkOutput("t2_sts_hold_valid", sts_tvalid, 1);
        checkOutput("t2_sts_hold_data", sts_tdata, 8'hE7);
        sts_tready = 1'b1;
        tick();
        sts_tready = 1'b0;
        checkOutput("t2_sts_done", sts_tvalid, 0);
        checkOutput("t2_cnt_rej", cnt_rejected, 1);
        checkOutput("t2_cnt_acc", cnt_accepted, 1);

        $display("[TB] step 3: fill with engine stalled, then drain");
        for (int i = 0; i < 5; i++) begin
            checkOutput("t3_ready_fill", cmd_tready, 1);
            applyStimulus(mk_cmd(4'((i % 3) + 1), 8'(8'h10 + i), 32'(32'h100 + i), 64'(64'hC0DE_0000 + i)));
        end
        checkOutput("t3_full_tready", cmd_tready, 0);
        checkOutput("t3_full_level", fifo_level, 4);
        eng_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checkOutput("t3_drain_valid", eng_valid, 1);
            checkOutput("t3_drain_tag", eng_tag, 8'h10 + i);
            checkOutput("t3_drain_op", eng_op, (i % 3) + 1);
            checkOutput("t3_drain_key", eng_key, 32'h100 + i);
            if (i == 1) checkOutput("t3_ready_after_pop", cmd_tready, 1);
            tick();
        end
        eng_ready = 1'b0;
        checkOutput("t3_idle", eng_valid, 0);
        checkOutput("t3_cnt_acc", cnt_accepted, 6);

        $display("[TB] step 4: SEARCH, bad op 0, DELETE with status stall");
        eng_ready = 1'b1;
        applyStimulus(mk_cmd(4'h3, 8'h20, 32'hAAAA, 64'h1));
        applyStimulus(mk_cmd(4'h0, 8'h21, 32'hBBBB, 64'h2));
        checkOutput("t4_search_valid", eng_valid, 1);
        checkOutput("t4_search_tag", eng_tag, 8'h20);
        applyStimulus(mk_cmd(4'h2, 8'h22, 32'hCCCC, 64'h3));
        for (int i = 0; i < 3; i++) begin
            checkOutput("t4_stall_sts", sts_tvalid, 1);
            checkOutput("t4_stall_data", sts_tdata, 8'hE0);
            checkOutput("t4_stall_no_eng", eng_valid, 0);
            tick();
        end
        checkOutput("t4_cnt_acc_mid", cnt_accepted, 7);
        sts_tready = 1'b1;
        tick();
        sts_tready = 1'b0;
        checkOutput("t4_delete_valid", eng_valid, 1);
        checkOutput("t4_delete_tag", eng_tag, 8'h22);
        checkOutput("t4_delete_op", eng_op, 2);
        checkOutput("t4_cnt_rej", cnt_rejected, 2);
        tick();
        eng_ready = 1'b0;
        checkOutput("t4_idle", eng_valid, 0);
        checkOutput("t4_cnt_acc", cnt_accepted, 8);

        $display("[TB] step 5: flush with a pending command");
        for (int i = 0; i < 4; i++)
            applyStimulus(mk_cmd(4'h1, 8'(8'h30 + i), 32'h0, 64'h0));
        checkOutput("t5_level_pre", fifo_level, 3);
        checkOutput("t5_pending_tag", eng_tag, 8'h30);
        csr_flush = 1'b1;
        tick();
        csr_flush = 1'b0;
        checkOutput("t5_level_flushed", fifo_level, 0);
        checkOutput("t5_still_valid", eng_valid, 1);
        checkOutput("t5_still_tag", eng_tag, 8'h30);
        eng_ready = 1'b1;
        tick();
        checkOutput("t5_done", eng_valid, 0);
        checkOutput("t5_cnt_acc", cnt_accepted, 9);
        tick();
        eng_ready = 1'b0;
        checkOutput("t5_stay_idle", eng_valid, 0);
        checkOutput("t5_cnt_acc_hold", cnt_accepted, 9);

        $display("[TB] step 6: disabled input, then reset mid-ISSUE");
        csr_enable = 1'b0;
        cmd_tvalid = 1'b1;
        cmd_tdata  = mk_cmd(4'h1, 8'h40, 32'h4, 64'h4);
        #1;
        for (int i = 0; i < 4; i++) begin
            checkOutput("t6_disabled_tready", cmd_tready, 0);
            tick();
        end
        checkOutput("t6_disabled_level", fifo_level, 0);
        checkOutput("t6_disabled_valid", eng_valid, 0);
        csr_enable = 1'b1;
        applyStimulus(mk_cmd(4'h1, 8'h41, 32'h5, 64'h5));
        tick();
        checkOutput("t6_issue_valid", eng_valid, 1);
        checkOutput("t6_issue_tag", eng_tag, 8'h41);
        aresetn = 1'b0;
        #1;
        checkOutput("t6_rst_valid", eng_valid, 0);
        checkOutput("t6_rst_cnt_acc", cnt_accepted, 0);
        checkOutput("t6_rst_cnt_rej", cnt_rejected, 0);
        checkOutput("t6_rst_level", fifo_level, 0);
        tick();
        aresetn = 1'b1;
        tick();
        checkOutput("t6_post_rst_idle", eng_valid, 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: observed running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
